// File: rtl/mmio_out_fifo.sv
// rtl/mmio_out_fifo.sv - memory-mapped output FIFO port on the core data-memory bus
// Window stores to DATA feed a first-word-fall-through FIFO drained over valid/ready.
module mmio_out_fifo #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        io_hit,
  output logic [31:0] io_rd,
  output logic        dmem_we,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    dropcnt_q, dropcnt_d;

  logic [5:0]    reg_sel;
  logic          wr_hit;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          empty;
  logic          full;
  logic [7:0]    count8;

  always_comb begin
    reg_sel   = dataadr[7:2];
    io_hit    = (dataadr[31:8] == BASE[31:8]);
    dmem_we   = memwrite & ~io_hit;
    wr_hit    = memwrite & io_hit;
    push_req  = wr_hit & (reg_sel == 6'd0);
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    push_ok   = push_req & ~full;
    pop       = ~empty & out_ready;
    out_valid = ~empty;
    out_data  = mem_q[rd_ptr_q];
    count8    = 8'(count_q);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropcnt_d  = dropcnt_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop is a DATA store while full; clears come from other offsets, so they never collide.
    if (push_req && full) begin
      overflow_d = 1'b1;
      if (dropcnt_q != 8'hFF) dropcnt_d = dropcnt_q + 8'd1;
    end else if (wr_hit && reg_sel == 6'd1) begin
      overflow_d = 1'b0;
    end else if (wr_hit && reg_sel == 6'd2) begin
      dropcnt_d = 8'd0;
    end
  end

  always_comb begin
    io_rd = 32'd0;
    if (io_hit) begin
      case (reg_sel)
        6'd1:    io_rd = {16'd0, count8, 5'd0, overflow_q, full, empty};
        6'd2:    io_rd = {24'd0, dropcnt_q};
        default: io_rd = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropcnt_q  <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropcnt_q  <= dropcnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= writedata;
  end

endmodule

// File: tb/tb_mmio_out_fifo.sv
// tb/tb_mmio_out_fifo.sv - directed self-checking bench for mmio_out_fifo
module tb_mmio_out_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        io_hit;
  logic [31:0] io_rd;
  logic        dmem_we;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] A_DATA = 32'hFFFF_FF00;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF04;
  localparam logic [31:0] A_DROP = 32'hFFFF_FF08;

  mmio_out_fifo #(.DEPTH(8), .BASE(32'hFFFF_FF00)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .io_hit    (io_hit),
    .io_rd     (io_rd),
    .dmem_we   (dmem_we),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0;
    dataadr  = a;
    #1;
    chk(tag, io_rd, exp);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input bit check_we);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    #1;
    if (check_we) chk("dmem_we_on_io_store", {31'd0, dmem_we}, 32'd0);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
    out_ready = 1'b0;
    #12;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    rd("reset_status", A_STAT, 32'h0000_0001);
    rd("reset_drop", A_DROP, 32'h0000_0000);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Three stores, consumer idle
    st(A_DATA, 32'h11, 1'b1);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    st(A_DATA, 32'h22, 1'b1);
    st(A_DATA, 32'h33, 1'b1);
    rd("status_3", A_STAT, 32'h0000_0300);
    rd("data_reads_zero", A_DATA, 32'h0);
    chk("head_11", out_data, 32'h11);

    // Drain in order
    out_ready = 1'b1;
    chk("drain_0", out_data, 32'h11);
    @(posedge clk); #1;
    chk("drain_1", out_data, 32'h22);
    @(posedge clk); #1;
    chk("drain_2", out_data, 32'h33);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drained_valid", {31'd0, out_valid}, 32'd0);
    rd("status_empty", A_STAT, 32'h0000_0001);

    // Ten pushes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) st(A_DATA, 32'h100 + i, 1'b1);
    rd("status_full_ovf", A_STAT, 32'h0000_0806);
    rd("drop_2", A_DROP, 32'h0000_0002);
    chk("head_after_ovf", out_data, 32'h100);
    st(A_STAT, 32'h1234, 1'b1);
    rd("status_ovf_clr", A_STAT, 32'h0000_0802);
    rd("drop_kept", A_DROP, 32'h0000_0002);
    st(A_DROP, 32'h0, 1'b1);
    rd("drop_clr", A_DROP, 32'h0000_0000);

    // Full with simultaneous pop: push dropped, pop proceeds
    out_ready = 1'b1;
    st(A_DATA, 32'hDEAD, 1'b1);
    rd("status_full_pop", A_STAT, 32'h0000_0704);
    rd("drop_full_pop", A_DROP, 32'h0000_0001);
    chk("head_full_pop", out_data, 32'h101);
    st(A_DATA, 32'hBEEF, 1'b1);
    out_ready = 1'b0;
    rd("status_push_pop", A_STAT, 32'h0000_0704);
    chk("head_push_pop", out_data, 32'h102);

    // Outside the window and unused window offsets
    memwrite = 1'b1; dataadr = 32'h0000_0040; writedata = 32'hCAFE;
    #1;
    chk("outside_hit", {31'd0, io_hit}, 32'd0);
    chk("outside_we", {31'd0, dmem_we}, 32'd1);
    chk("outside_rd", io_rd, 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0;
    rd("status_after_outside", A_STAT, 32'h0000_0704);
    dataadr = 32'hFFFF_FF80;
    #1;
    chk("unused_hit", {31'd0, io_hit}, 32'd1);
    chk("unused_rd", io_rd, 32'd0);
    st(32'hFFFF_FF80, 32'h55, 1'b1);
    rd("status_after_unused", A_STAT, 32'h0000_0704);

    // Push 5, pop 2, then an asynchronous mid-cycle reset
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 5; i++) st(A_DATA, 32'h40 + i, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("head_after_pop2", out_data, 32'h42);
    rd("status_3_left", A_STAT, 32'h0000_0300);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    rd("async_reset_status", A_STAT, 32'h0000_0001);
    reset = 1'b0;
    @(posedge clk); #1;

    // Drop counter saturation
    for (int i = 0; i < 8 + 254; i++) st(A_DATA, 32'h200 + i, 1'b0);
    rd("drop_254", A_DROP, 32'h0000_00FE);
    for (int i = 0; i < 6; i++) st(A_DATA, 32'h300 + i, 1'b0);
    rd("drop_sat", A_DROP, 32'h0000_00FF);
    rd("status_sat", A_STAT, 32'h0000_0806);
    chk("head_sat", out_data, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
